// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared FSM state type and default operand width for serial arithmetic blocks
package serial_arith_pkg;
  localparam int DEFAULT_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit difference and borrow stage, reused once per serial bit
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor_4bit.sv
// serial_subtractor_4bit: LSB-first bit-serial a - b - bin with registered result and flags
module serial_subtractor_4bit
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
  logic             br_q, busy_q, done_q, bout_q, ovf_q, zero_q;
  logic             fs_d, fs_b;
  full_subtractor u_fs (.x(a_q[0]), .y(b_q[0]), .bin(br_q), .d(fs_d), .bout(fs_b));
  // On the final bit a_q[0]/b_q[0] hold the operand sign bits and fs_d is the result sign bit
  wire [WIDTH-1:0] res_d  = {fs_d, res_q[WIDTH-1:1]};
  wire             last_d = cnt_q == CW'(WIDTH - 1);
  wire             ovf_d  = (a_q[0] ^ b_q[0]) & (fs_d ^ a_q[0]);
  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
  // Control FSM, serial datapath and result registers; ena low freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else if (ena) begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= fs_b;
          res_q <= res_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_d) begin
            diff_q  <= res_d;
            bout_q  <= fs_b;
            ovf_q   <= ovf_d;
            zero_q  <= res_d == '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// tb_serial_subtractor_4bit: directed checks of the serial subtractor with hand-computed results
module tb_serial_subtractor_4bit;
  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0, start = 1'b0, bin = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic       busy, done, bout, ovf, zero;
  logic [3:0] diff;
  int         n_cmp = 0, n_err = 0;
  logic [3:0] last_diff = '0;
  logic [3:0] ta [4] = '{4'd7, 4'd3, 4'd8, 4'd5};
  logic [3:0] tb [4] = '{4'd3, 4'd7, 4'd1, 4'd5};
  logic [3:0] td [4] = '{4'd4, 4'd12, 4'd7, 4'd0};

  serial_subtractor_4bit #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] oa, input logic [3:0] ob, input logic obin,
                        input logic [3:0] ed, input logic eb, input logic eo, input logic ez,
                        input string tag);
    @(negedge clk);
    a = oa; b = ob; bin = obin; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 1) begin a = ~oa; b = ~ob; bin = ~obin; end
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_nodone"}, done, 0);
      chk({tag, "_hold"}, diff, last_diff);
    end
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_idlebusy"}, busy, 0);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bout"}, bout, eb);
    chk({tag, "_ovf"}, ovf, eo);
    chk({tag, "_zero"}, zero, ez);
    last_diff = ed;
    @(negedge clk);
    chk({tag, "_pulse"}, done, 0);
    chk({tag, "_keep"}, diff, ed);
  endtask

  initial begin
    ena = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_zero", zero, 1);
    rst_n = 1'b1;

    run_op(4'd7, 4'd3, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, "s7m3");
    run_op(4'd3, 4'd7, 1'b0, 4'd12, 1'b1, 1'b0, 1'b0, "s3m7");
    run_op(4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0, "s0m0b");
    run_op(4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0, "s8m1");
    run_op(4'd5, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, "s5m5");

    // start ignored mid-run, three frozen cycles: done seven edges after start
    @(negedge clk);
    a = 4'd9; b = 4'd2; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 4'd1; b = 4'd1;
    @(negedge clk);
    start = 1'b0; ena = 1'b0;
    @(negedge clk);
    chk("gap_nodone3", done, 0);
    @(negedge clk);
    chk("gap_busy4", busy, 1);
    @(negedge clk);
    chk("gap_nodone5", done, 0);
    ena = 1'b1;
    @(negedge clk);
    chk("gap_nodone6", done, 0);
    chk("gap_busy6", busy, 1);
    @(negedge clk);
    chk("gap_done7", done, 1);
    chk("gap_diff", diff, 7);
    chk("gap_ovf", ovf, 1);
    chk("gap_bout", bout, 0);
    @(negedge clk);
    chk("gap_single", done, 0);
    chk("gap_idle", busy, 0);
    @(negedge clk);
    chk("gap_single2", done, 0);

    // start held high: a completion every five cycles
    a = ta[0]; b = tb[0]; bin = 1'b0; start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        chk("b2b_nodone", done, 0);
      end
      @(negedge clk);
      chk("b2b_done", done, 1);
      chk("b2b_diff", diff, td[k]);
      if (k < 3) begin a = ta[k + 1]; b = tb[k + 1]; end
      else start = 1'b0;
    end
    last_diff = 4'd0;

    run_op(4'd3, 4'd7, 1'b0, 4'd12, 1'b1, 1'b0, 1'b0, "pre_rst");

    // reset two edges into a run
    @(negedge clk);
    a = 4'd9; b = 4'd4; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_diff", diff, 0);
    chk("ar_bout", bout, 0);
    chk("ar_zero", zero, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("ar_nodone", done, 0);
    end
    last_diff = 4'd0;
    run_op(4'd6, 4'd2, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, "s6m2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
